bg_tile_fetch_seq: RTL and testbench

//  Sequences PPU background tile fetches over a shared VRAM read port.

---
 rtl/bg_tile_fetch_seq.sv | 143 ++++++++++++++
 tb/tb_bg_tile_fetch_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_tile_fetch_seq.sv
// Background tile fetch sequencer: per tile, reads nametable, attribute and both
// pattern planes over a shared VRAM port, then steps coarse X for a burst of tiles.
module bg_tile_fetch_seq #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] nt_addr,
  input  logic [CNT_W-1:0]  tile_count,
  input  logic [2:0]        fine_y,
  input  logic              pt_sel,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              tile_valid,
  output logic [7:0]        tile_pat_lo,
  output logic [7:0]        tile_pat_hi,
  output logic [1:0]        tile_palette
);

  typedef enum logic [2:0] {
    S_IDLE, S_NT, S_AT, S_PLO, S_PHI, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        fine_y_q;
  logic              pt_sel_q;
  logic [CNT_W-1:0]  remaining;
  logic [7:0]        tile_idx;
  logic [1:0]        pal_q;
  logic [7:0]        lo_q;

  logic [ADDR_W-1:0] at_addr, pat_addr, addr_step;
  logic [1:0]        pal_sel;
  logic [CNT_W-1:0]  rem_dec;
  logic              accept;

  assign accept  = start && (tile_count != '0) && !abort;
  assign rem_dec = remaining - CNT_W'(1);
  // Attribute quadrant picks the 2-bit field: {row[1], col[1]}
  assign pal_sel = {addr_q[6], addr_q[1]};
  assign at_addr  = {addr_q[ADDR_W-1:10], 4'b1111, addr_q[9:7], addr_q[4:2]};
  assign pat_addr = ADDR_W'({pt_sel_q, tile_idx, 1'b0, fine_y_q});

  // Coarse-X step; column 31 wraps to column 0 of the horizontally adjacent nametable
  always_comb begin
    addr_step = addr_q + ADDR_W'(1);
    if (addr_q[4:0] == 5'h1F) begin
      addr_step       = addr_q;
      addr_step[4:0]  = 5'h00;
      addr_step[10]   = ~addr_q[10];
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_req     = 1'b0;
    rd_addr    = '0;
    tile_valid = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_NT;
      S_NT: begin
        rd_req  = 1'b1;
        rd_addr = addr_q;
        if (rd_ack) state_nxt = S_AT;
      end
      S_AT: begin
        rd_req  = 1'b1;
        rd_addr = at_addr;
        if (rd_ack) state_nxt = S_PLO;
      end
      S_PLO: begin
        rd_req  = 1'b1;
        rd_addr = pat_addr;
        if (rd_ack) state_nxt = S_PHI;
      end
      S_PHI: begin
        rd_req     = 1'b1;
        rd_addr    = pat_addr;
        rd_addr[3] = 1'b1;
        if (rd_ack) state_nxt = S_DONE;
      end
      S_DONE: begin
        tile_valid = 1'b1;
        state_nxt  = (rem_dec != '0) ? S_NT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      fine_y_q     <= '0;
      pt_sel_q     <= 1'b0;
      remaining    <= '0;
      tile_idx     <= '0;
      pal_q        <= '0;
      lo_q         <= '0;
      tile_pat_lo  <= '0;
      tile_pat_hi  <= '0;
      tile_palette <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          addr_q    <= nt_addr;
          fine_y_q  <= fine_y;
          pt_sel_q  <= pt_sel;
          remaining <= tile_count;
        end
        S_NT:  if (rd_ack) tile_idx <= rd_data;
        S_AT:  if (rd_ack) pal_q <= rd_data[{pal_sel, 1'b0} +: 2];
        S_PLO: if (rd_ack) lo_q <= rd_data;
        // Results only publish for a completed tile; they hold until the next DONE
        S_PHI: if (rd_ack && !abort) begin
          tile_pat_lo  <= lo_q;
          tile_pat_hi  <= rd_data;
          tile_palette <= pal_q;
        end
        S_DONE: begin
          remaining <= rem_dec;
          if (rem_dec != '0) addr_q <= addr_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bg_tile_fetch_seq.sv
// Bench for bg_tile_fetch_seq: VRAM responder, read/tile scoreboard, table of bursts
// and hand-timed sequences for wrap, wait states, abort, busy start and reset.
module tb_bg_tile_fetch_seq;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort;
  logic [ADDR_W-1:0] nt_addr;
  logic [CNT_W-1:0]  tile_count;
  logic [2:0]        fine_y;
  logic              pt_sel;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [7:0]        rd_data;
  logic              busy, tile_valid;
  logic [7:0]        tile_pat_lo, tile_pat_hi;
  logic [1:0]        tile_palette;

  bg_tile_fetch_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .nt_addr(nt_addr),
    .tile_count(tile_count), .fine_y(fine_y), .pt_sel(pt_sel), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .busy(busy),
    .tile_valid(tile_valid), .tile_pat_lo(tile_pat_lo), .tile_pat_hi(tile_pat_hi),
    .tile_palette(tile_palette)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] pal;
  } tile_t;

  typedef struct {
    logic [15:0] nt;
    int          cnt;
    logic        ps;
    logic [2:0]  fy;
    bit          rws;
    int          exp_tiles;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_addr_q[$];
  tile_t       exp_tile_q[$];
  logic [7:0]  mem [int];
  int          ws_left = 0;
  bit          rand_ws = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h required=0x%0h", name, got, exp);
    end
  endfunction

  function automatic logic [7:0] vram(logic [15:0] ad);
    if (mem.exists(int'(ad))) return mem[int'(ad)];
    return (ad[7:0] * 8'd7) ^ ad[15:8] ^ 8'h3C;
  endfunction

  // Reference model: expected read addresses and tile results of a whole burst
  function automatic void push_burst(logic [15:0] a0, int cnt, logic ps, logic [2:0] fy);
    logic [15:0] a, ata, pla;
    logic [7:0]  idx, attr, sh;
    tile_t       t;
    a = a0;
    for (int i = 0; i < cnt; i++) begin
      ata  = {a[15:10], 4'b1111, a[9:7], a[4:2]};
      idx  = vram(a);
      attr = vram(ata);
      pla  = {3'b000, ps, idx, 1'b0, fy};
      exp_addr_q.push_back(a);
      exp_addr_q.push_back(ata);
      exp_addr_q.push_back(pla);
      exp_addr_q.push_back(pla | 16'h0008);
      sh    = attr >> (2 * {a[6], a[1]});
      t.lo  = vram(pla);
      t.hi  = vram(pla | 16'h0008);
      t.pal = sh[1:0];
      exp_tile_q.push_back(t);
      if (a[4:0] == 5'd31) a = (a & 16'hFFE0) ^ 16'h0400;
      else                 a = a + 16'd1;
    end
  endfunction

  // VRAM responder: optional wait states on attribute reads or random stalls
  initial begin
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rd_req && ws_left > 0 && rd_addr[13] && rd_addr[9:6] == 4'hF) begin
        rd_ack = 1'b0;
        ws_left--;
      end else if (rand_ws)
        rd_ack = rd_req ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      else
        rd_ack = rd_req;
      rd_data = vram(rd_addr);
    end
  end

  // Scoreboard monitor
  initial begin
    tile_t t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rd_req && rd_ack) begin
          if (exp_addr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_read: got addr=0x%0h required=no read", rd_addr);
          end else check("sb_rd_addr", rd_addr, exp_addr_q.pop_front());
        end
        if (tile_valid) begin
          if (exp_tile_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tile: got tile_valid=1 required=0");
          end else begin
            t = exp_tile_q.pop_front();
            check("sb_pat_lo", tile_pat_lo, t.lo);
            check("sb_pat_hi", tile_pat_hi, t.hi);
            check("sb_palette", tile_palette, t.pal);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge; returns at the negedge of the first cycle after start
  task automatic start_burst(logic [15:0] a, int cnt, logic ps, logic [2:0] fy);
    nt_addr    = a;
    tile_count = CNT_W'(cnt);
    pt_sel     = ps;
    fine_y     = fy;
    start      = 1'b1;
    push_burst(a, cnt, ps, fy);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int pulses);
    int n;
    pulses = 0;
    n = 0;
    while (busy && n < 600) begin
      if (tile_valid) pulses++;
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=1 required=0");
    end
  endtask

  initial begin
    vec_t        vecs[5];
    int          pulses;
    logic [15:0] seen[$];
    int          tv[$];

    vecs[0] = '{16'h2000, 3, 1'b0, 3'd2, 1'b0, 3};
    vecs[1] = '{16'h23BE, 4, 1'b1, 3'd7, 1'b1, 4};
    vecs[2] = '{16'h2C5D, 5, 1'b0, 3'd1, 1'b1, 5};
    vecs[3] = '{16'h2FBF, 2, 1'b1, 3'd4, 1'b0, 2};
    vecs[4] = '{16'h241E, 0, 1'b0, 3'd0, 1'b0, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; nt_addr = '0;
    tile_count = '0; fine_y = '0; pt_sel = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_tile_valid", tile_valid, 0);
    check("rst_outs", {tile_pat_lo, tile_pat_hi, tile_palette}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single tile, zero wait
    mem[32'h2043] = 8'h41; mem[32'h23C0] = 8'hC0;
    mem[32'h1415] = 8'hAA; mem[32'h141D] = 8'h55;
    start_burst(16'h2043, 1, 1'b1, 3'd5);
    check("st_req_nt", rd_req, 1);
    check("st_addr_nt", rd_addr, 16'h2043);
    @(negedge clk); check("st_addr_at", rd_addr, 16'h23C0);
    @(negedge clk); check("st_addr_plo", rd_addr, 16'h1415);
    @(negedge clk); check("st_addr_phi", rd_addr, 16'h141D);
    @(negedge clk);
    check("st_valid", tile_valid, 1);
    check("st_lo", tile_pat_lo, 8'hAA);
    check("st_hi", tile_pat_hi, 8'h55);
    check("st_pal", tile_palette, 2'd3);
    @(negedge clk);
    check("st_valid_end", tile_valid, 0);
    check("st_idle", busy, 0);
    check("st_hold_lo", tile_pat_lo, 8'hAA);

    // Nametable wrap over two tiles
    start_burst(16'h201F, 2, 1'b0, 3'd0);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (rd_req && rd_ack) seen.push_back(rd_addr);
      if (tile_valid) tv.push_back(cyc);
      @(negedge clk);
    end
    check("wrap_nreads", seen.size(), 8);
    check("wrap_nt2", (seen.size() > 4) ? 32'(seen[4]) : 32'hDEAD, 16'h2400);
    check("wrap_at2", (seen.size() > 5) ? 32'(seen[5]) : 32'hDEAD, 16'h27C0);
    check("wrap_npulse", tv.size(), 2);
    check("wrap_first", (tv.size() > 0) ? tv[0] : -1, 5);
    check("wrap_gap", (tv.size() > 1) ? tv[1] - tv[0] : -1, 5);

    // Three wait states on the attribute read
    ws_left = 3;
    start_burst(16'h2043, 1, 1'b1, 3'd5);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("ws_req", rd_req, 1);
      check("ws_addr", rd_addr, 16'h23C0);
    end
    @(negedge clk); @(negedge clk);
    check("ws_valid_t7", tile_valid, 0);
    @(negedge clk);
    check("ws_valid_t8", tile_valid, 1);
    @(negedge clk);

    // Abort during pattern-low fetch of tile 1 of 3
    start_burst(16'h2000, 3, 1'b0, 3'd2);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_req", rd_req, 0);
    check("ab_busy", busy, 0);
    exp_addr_q.delete();
    exp_tile_q.delete();
    start_burst(16'h2100, 1, 1'b0, 3'd1);
    check("ab_restart_busy", busy, 1);
    check("ab_restart_addr", rd_addr, 16'h2100);
    wait_idle(pulses);
    check("ab_restart_tiles", pulses, 1);

    // start with zero count
    nt_addr = 16'h2000; tile_count = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c0_busy", busy, 0);
    check("c0_req", rd_req, 0);
    @(negedge clk);
    check("c0_busy2", busy, 0);

    // start while busy must not restart or resize the burst
    start_burst(16'h2080, 2, 1'b1, 3'd6);
    @(negedge clk);
    nt_addr = 16'h2300; tile_count = CNT_W'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(pulses);
    check("busy_start_tiles", pulses, 2);

    // Table of bursts
    foreach (vecs[i]) begin
      rand_ws = vecs[i].rws;
      start_burst(vecs[i].nt, vecs[i].cnt, vecs[i].ps, vecs[i].fy);
      wait_idle(pulses);
      check("vec_tiles", pulses, vecs[i].exp_tiles);
      rand_ws = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("sb_addr_drained", exp_addr_q.size(), 0);
    check("sb_tile_drained", exp_tile_q.size(), 0);

    // Reset asserted in the pattern-high fetch of the second tile
    start_burst(16'h2040, 2, 1'b1, 3'd3);
    repeat (8) @(negedge clk);
    check("rm_req_phi", rd_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_req", rd_req, 0);
    check("rm_busy", busy, 0);
    check("rm_addr", rd_addr, 0);
    check("rm_valid", tile_valid, 0);
    check("rm_outs", {tile_pat_lo, tile_pat_hi, tile_palette}, 0);
    exp_addr_q.delete();
    exp_tile_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_idle_busy", busy, 0);
    check("rm_idle_req", rd_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
